// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg -- shared types for the program-counter unit.
//   state_e  : RUN / HALT / FAULT control states
//   action_e : one-per-cycle PC action chosen in RUN
//   sel_action() : fixed-priority decode of the command inputs (halt handled
//                  separately by the caller since it changes state, not PC)
package pc_unit_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        INC  = 3'd1,
        SKIP = 3'd2,
        LOAD = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5
    } action_e;

    // ret > call > load > skip > inc > hold
    function automatic action_e sel_action(input logic ret, input logic call,
                                           input logic load, input logic skip,
                                           input logic inc);
        if (ret)       return RET;
        else if (call) return CALL;
        else if (load) return LOAD;
        else if (skip) return SKIP;
        else if (inc)  return INC;
        else           return HOLD;
    endfunction

endpackage

// File: rtl/pc_stack.sv
// pc_stack -- return-address LIFO.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears sp only)
//   push, pop     : push data_in / pop top; ignored when full / empty
//   data_in       : value to push
//   top           : entry at the top of the stack (valid when !empty)
//   sp            : occupancy, 0..DEPTH
//   full, empty   : sp == DEPTH / sp == 0
module pc_stack
    import pc_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             data_in,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_idx;
    logic [PW-1:0]           top_idx;

    // sp counts entries, so the next free slot is sp and the top is sp-1;
    // the low bits index correctly because DEPTH is a power of two.
    assign wr_idx  = sp[PW-1:0];
    assign top_idx = sp[PW-1:0] - PW'(1);
    assign top     = mem[top_idx];
    assign full    = (sp == (PW+1)'(DEPTH));
    assign empty   = (sp == '0);

    always_ff @(posedge clk) begin
        if (rst)
            sp <= '0;
        else if (push && !full)
            sp <= sp + (PW+1)'(1);
        else if (pop && !empty)
            sp <= sp - (PW+1)'(1);
    end

    // Contents are not reset; only sp defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push && !full)
            mem[wr_idx] <= data_in;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- program counter with RUN/HALT/FAULT control and optional
// return stack.
// Build option: define PC_UNIT_STACK_EN to include the return stack
// (call/ret with overflow/underflow FAULT). Without it call acts as a jump,
// ret holds, sp_out and fault are constant 0.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   inc_pc, skip    : PC += 1 / PC += 2 (wrapping)
//   load_pc, call   : PC <= pc_in (call also pushes PC+1)
//   ret             : PC <= popped return address
//   halt, resume    : enter / leave HALT
//   pc_in           : jump / call target
//   pc_out          : current PC (register)
//   running, fault  : state flags (registers)
//   sp_out          : stack occupancy (register)
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc_pc,
    input  logic                         skip,
    input  logic                         load_pc,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         halt,
    input  logic                         resume,
    input  logic [ADDR_WIDTH-1:0]        pc_in,
    output logic [ADDR_WIDTH-1:0]        pc_out,
    output logic                         running,
    output logic                         fault,
    output logic [$clog2(STACK_DEPTH):0] sp_out
);
    state_e                state_q, state_d;
    action_e               act;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

`ifdef PC_UNIT_STACK_EN
    logic                         push, pop;
    logic                         stk_full, stk_empty;
    logic [ADDR_WIDTH-1:0]        stk_top;
    logic [$clog2(STACK_DEPTH):0] stk_sp;
    logic                         fault_q;

    pc_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_WIDTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .data_in (pc_q + ADDR_WIDTH'(1)),
        .top     (stk_top),
        .sp      (stk_sp),
        .full    (stk_full),
        .empty   (stk_empty)
    );
`endif

    always_comb begin
        act     = sel_action(ret, call, load_pc, skip, inc_pc);
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_UNIT_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALT;
                end else begin
                    case (act)
                        INC:  pc_d = pc_q + ADDR_WIDTH'(1);
                        SKIP: pc_d = pc_q + ADDR_WIDTH'(2);
                        LOAD: pc_d = pc_in;
`ifdef PC_UNIT_STACK_EN
                        // Overflow/underflow leave PC and stack untouched.
                        CALL: begin
                            if (stk_full) begin
                                state_d = FAULT;
                            end else begin
                                push = 1'b1;
                                pc_d = pc_in;
                            end
                        end
                        RET: begin
                            if (stk_empty) begin
                                state_d = FAULT;
                            end else begin
                                pop  = 1'b1;
                                pc_d = stk_top;
                            end
                        end
`else
                        CALL: pc_d = pc_in;
                        RET:  pc_d = pc_q;
`endif
                        default: pc_d = pc_q;
                    endcase
                end
            end
            HALT:    if (resume) state_d = RUN;
            FAULT:   state_d = FAULT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            running <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            running <= (state_d == RUN);
        end
    end

    assign pc_out = pc_q;

`ifdef PC_UNIT_STACK_EN
    // Separate flag register so fault is a flop output, not a state decode.
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= (state_d == FAULT);
    end
    assign fault  = fault_q;
    assign sp_out = stk_sp;
`else
    assign fault  = 1'b0;
    assign sp_out = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_pc_unit;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst, inc_pc, skip, load_pc, call, ret, halt, resume;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] pc_out;
    logic          running, fault;
    logic [$clog2(DEPTH):0] sp_out;

    int tests = 0;
    int fails = 0;

    // model: 0 = running, 1 = halted, 2 = faulted
    int m_st;
    int m_pc;
    int m_stk[$];
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_unit #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .inc_pc(inc_pc), .skip(skip), .load_pc(load_pc),
        .call(call), .ret(ret), .halt(halt), .resume(resume), .pc_in(pc_in),
        .pc_out(pc_out), .running(running), .fault(fault), .sp_out(sp_out)
    );

    task automatic model_step();
        if (rst) begin
            m_st = 0; m_pc = 0; m_stk.delete();
        end else if (m_st == 1) begin
            if (resume) m_st = 0;
        end else if (m_st == 0) begin
            if (halt) m_st = 1;
            else if (ret) begin
`ifdef PC_UNIT_STACK_EN
                if (m_stk.size() == 0) m_st = 2;
                else m_pc = m_stk.pop_back();
`endif
            end else if (call) begin
`ifdef PC_UNIT_STACK_EN
                if (m_stk.size() == DEPTH) m_st = 2;
                else begin
                    m_stk.push_back((m_pc + 1) % (MASK + 1));
                    m_pc = int'(pc_in);
                end
`else
                m_pc = int'(pc_in);
`endif
            end
            else if (load_pc) m_pc = int'(pc_in);
            else if (skip)    m_pc = (m_pc + 2) % (MASK + 1);
            else if (inc_pc)  m_pc = (m_pc + 1) % (MASK + 1);
        end
    endtask

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (int'(pc_out) != m_pc) begin
                fails++; $display("FAIL pc: got %0h want %0h at %0t", pc_out, m_pc, $time);
            end
            tests++;
            if (int'(sp_out) != m_stk.size()) begin
                fails++; $display("FAIL sp: got %0d want %0d at %0t", sp_out, m_stk.size(), $time);
            end
            tests++;
            if (running != (m_st == 0)) begin
                fails++; $display("FAIL running: got %0b want %0b at %0t", running, m_st == 0, $time);
            end
            tests++;
            if (fault != (m_st == 2)) begin
                fails++; $display("FAIL fault: got %0b want %0b at %0t", fault, m_st == 2, $time);
            end
        end
    end

    task automatic lit(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++; $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // cmd bits: {rst, halt, resume, ret, call, load, skip, inc}
    task automatic cyc(input logic [7:0] cmd, input logic [AW-1:0] tgt);
        {rst, halt, resume, ret, call, load_pc, skip, inc_pc} = cmd;
        pc_in = tgt;
        @(posedge clk);
        #1 model_step();
        chk_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    localparam logic [7:0] C_RST = 8'h80, C_HALT = 8'h40, C_RES = 8'h20,
                           C_RET = 8'h10, C_CALL = 8'h08, C_LOAD = 8'h04,
                           C_SKIP = 8'h02, C_INC = 8'h01, C_NOP = 8'h00;

    initial begin
        {rst, halt, resume, ret, call, load_pc, skip, inc_pc} = 8'h80;
        pc_in = '0;
        @(negedge clk);

        // reset overrides every other command
        cyc(8'hFF, 8'h77);
        lit("rst_pc", int'(pc_out), 0); lit("rst_run", int'(running), 1);
        lit("rst_fault", int'(fault), 0); lit("rst_sp", int'(sp_out), 0);

        // counting and skip
        cyc(C_INC, 0); lit("inc1", int'(pc_out), 1);
        cyc(C_INC, 0); lit("inc2", int'(pc_out), 2);
        cyc(C_INC, 0); lit("inc3", int'(pc_out), 3);
        cyc(C_SKIP | C_INC, 0); lit("skip", int'(pc_out), 5);

        // wrap
        cyc(C_LOAD | C_SKIP, 8'hFE); lit("load", int'(pc_out), 'hFE);
        cyc(C_INC, 0); lit("wrap1", int'(pc_out), 'hFF);
        cyc(C_INC, 0); lit("wrap2", int'(pc_out), 'h00);
        cyc(C_LOAD, 8'hFF);
        cyc(C_SKIP, 0); lit("skipwrap", int'(pc_out), 'h01);

`ifdef PC_UNIT_STACK_EN
        cyc(C_LOAD, 8'h10);
        cyc(C_CALL | C_LOAD, 8'h40); lit("call_pc", int'(pc_out), 'h40); lit("call_sp", int'(sp_out), 1);
        cyc(C_RET | C_CALL, 8'h99); lit("ret_pc", int'(pc_out), 'h11); lit("ret_sp", int'(sp_out), 0);

        for (int i = 0; i < DEPTH; i++) cyc(C_CALL, AW'(8'h50 + i));
        lit("nest_sp", int'(sp_out), DEPTH);
        cyc(C_CALL, 8'hAA);
        lit("ovf_fault", int'(fault), 1); lit("ovf_run", int'(running), 0);
        lit("ovf_pc", int'(pc_out), 'h53);
        cyc(C_INC | C_RES, 0); lit("flt_pc", int'(pc_out), 'h53); lit("flt_hold", int'(fault), 1);
        cyc(C_RST, 0); lit("flt_rst_pc", int'(pc_out), 0); lit("flt_rst_f", int'(fault), 0);
        cyc(C_RET, 0); lit("unf_fault", int'(fault), 1);
        cyc(C_RST, 0);
`else
        cyc(C_CALL, 8'h20); lit("ncall_pc", int'(pc_out), 'h20); lit("ncall_sp", int'(sp_out), 0);
        cyc(C_RET, 0); lit("nret_pc", int'(pc_out), 'h20); lit("nret_f", int'(fault), 0);
`endif

        // halt / resume
        cyc(C_LOAD, 8'h30);
        cyc(C_HALT | C_INC, 0); lit("halt_pc", int'(pc_out), 'h30); lit("halt_run", int'(running), 0);
        for (int i = 0; i < 5; i++) cyc(C_INC | C_LOAD, 8'h05);
        lit("halt_hold", int'(pc_out), 'h30);
        cyc(C_RES | C_INC, 0); lit("res_run", int'(running), 1); lit("res_pc", int'(pc_out), 'h30);
        cyc(C_INC, 0); lit("res_inc", int'(pc_out), 'h31);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] c;
            c[7] = ($urandom_range(0, 79) == 0);
            c[6] = ($urandom_range(0, 11) == 0);
            c[5] = ($urandom_range(0, 3) == 0);
            c[4] = ($urandom_range(0, 5) == 0);
            c[3] = ($urandom_range(0, 4) == 0);
            c[2] = ($urandom_range(0, 5) == 0);
            c[1] = ($urandom_range(0, 3) == 0);
            c[0] = ($urandom_range(0, 1) == 0);
            cyc(c, AW'($urandom));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
